// File: rtl/downsample_2d_ctrl_pkg.sv
// downsample_2d_ctrl shared types.
// Controller states and decimation-factor clamp.
package ds_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // 0 behaves as 1, oversize factors saturate at max_dec
  function automatic int clamp_dec(int val, int max_dec);
    if (val < 1) return 1;
    if (val > max_dec) return max_dec;
    return val;
  endfunction

endpackage

// File: rtl/downsample_2d_ctrl_if.sv
// Pixel in/out handshake bundle for downsample_2d_ctrl.
// slave is the controller side, master the source/sink side.
interface downsample_2d_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid,
    input  out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid,
    output out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/downsample_2d_ctrl_mod_counter.sv
// Modulo counter with runtime limit; clr beats inc.
// wrap flags the increment that returns the count to 0.
module mod_counter #(
  parameter int modulus = 4,
  parameter int CW = $clog2(modulus + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  assign wrap = inc && (cnt + 1'b1 >= limit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/downsample_2d_ctrl.sv
// Frame controller for 2D pixel decimation.
// Kept pixels pass through combinationally; dropped ones are consumed.
module downsample_2d_ctrl
  import ds_ctrl_pkg::*;
#(
  parameter int in_width  = 240,
  parameter int in_height = 480,
  parameter int max_dec   = 4,
  parameter int DW = $clog2(max_dec + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_dec_x,
  input  logic [DW-1:0] cfg_dec_y,
  downsample_2d_ctrl_if.slave pix,
  output logic          busy,
  output logic          frame_done
);

  localparam int XW = $clog2(in_width + 1);
  localparam int YW = $clog2(in_height + 1);

  state_t state, state_nx;

  logic [DW-1:0] dx, dy, px, py;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic run, keep, hs, start_ok;
  logic x_last, y_last;
  logic px_wrap, py_wrap;
  logic unused_wrap;

  assign run      = state == RUN;
  assign start_ok = state == IDLE && start && !abort;
  assign keep     = px == '0 && py == '0;
  assign hs       = pix.in_valid && pix.in_ready;
  assign x_last   = x == XW'(in_width - 1);
  assign y_last   = y == YW'(in_height - 1);

  assign pix.in_ready  = run && (keep ? pix.out_ready : 1'b1);
  assign pix.out_valid = run && keep && pix.in_valid;
  assign pix.out_data  = pix.in_data;

  assign pix.out_sof = pix.out_valid && x == '0 && y == '0;
  assign pix.out_eol = pix.out_valid
                    && (int'(x) + int'(dx) >= in_width);
  assign pix.out_eof = pix.out_eol
                    && (int'(y) + int'(dy) >= in_height);

  assign busy       = state != IDLE;
  assign frame_done = state == DONE;

  assign unused_wrap = px_wrap | py_wrap;

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE:
        if (start_ok) state_nx = RUN;
      run:
        if (abort) state_nx = IDLE;
        else if (hs && x_last && y_last) state_nx = DONE;
      state == DONE:
        state_nx = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dx    <= DW'(1);
      dy    <= DW'(1);
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        dx <= DW'(clamp_dec(int'(cfg_dec_x), max_dec));
        dy <= DW'(clamp_dec(int'(cfg_dec_y), max_dec));
        x  <= '0;
        y  <= '0;
      end else if (hs) begin
        if (x_last) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  mod_counter #(.modulus(max_dec), .CW(DW)) u_px (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (hs),
    .clr    (start_ok || (hs && x_last)),
    .limit  (dx),
    .cnt    (px),
    .wrap   (px_wrap)
  );

  mod_counter #(.modulus(max_dec), .CW(DW)) u_py (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (hs && x_last),
    .clr    (start_ok),
    .limit  (dy),
    .cnt    (py),
    .wrap   (py_wrap)
  );

endmodule

// File: tb/tb_downsample_2d_ctrl.sv
// Testbench for downsample_2d_ctrl on an 8x4 frame.
// Reference: kept iff x%dx==0 and y%dy==0, last kept column/row by division.
module tb_downsample_2d_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int MD = 4;
  localparam int DW = $clog2(MD + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] cfg_dec_x = '0;
  logic [DW-1:0] cfg_dec_y = '0;
  logic          busy;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int pix   = 0;
  int edx   = 1;
  int edy   = 1;
  int salt  = 0;
  bit seq   = 1'b1;
  int outq[$];

  downsample_2d_ctrl_if bus();

  downsample_2d_ctrl #(
    .in_width (W),
    .in_height(H),
    .max_dec  (MD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .cfg_dec_x (cfg_dec_x),
    .cfg_dec_y (cfg_dec_y),
    .pix       (bus),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampf(int v);
    if (v < 1) return 1;
    if (v > MD) return MD;
    return v;
  endfunction

  // one cycle: drive after posedge, check at negedge, model at posedge
  task automatic cyc(input bit vld, input bit ord, output bit took);
    int x, y;
    bit k, er;
    x = pix % W;
    y = pix / W;
    k = (x % edx == 0) && (y % edy == 0);
    er = k ? ord : 1'b1;
    bus.in_valid  = vld;
    bus.out_ready = ord;
    bus.in_data   = seq ? 8'(pix) : 8'(pix * 37 + salt);
    @(negedge clk);
    chk("in_ready", bus.in_ready, er);
    chk("out_valid", bus.out_valid, vld && k);
    chk("out_data", bus.out_data, bus.in_data);
    if (vld && k) begin
      chk("sof", bus.out_sof, pix == 0);
      chk("eol", bus.out_eol,
          x == ((W - 1) / edx) * edx);
      chk("eof", bus.out_eof,
          x == ((W - 1) / edx) * edx &&
          y == ((H - 1) / edy) * edy);
    end
    @(posedge clk);
    took = vld && er;
    if (took && k) outq.push_back(int'(bus.in_data));
    if (took) pix++;
    #1;
  endtask

  task automatic do_start(input int cx, input int cy);
    start = 1'b1;
    cfg_dec_x = DW'(cx);
    cfg_dec_y = DW'(cy);
    @(posedge clk);
    #1;
    start = 1'b0;
    pix = 0;
    edx = clampf(cx);
    edy = clampf(cy);
    outq.delete();
    salt = int'($urandom_range(0, 255));
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_rest(input int pv, input int pr);
    int n;
    bit took;
    n = 0;
    while (pix < W * H && n < 3000) begin
      cyc($urandom_range(0, 99) < pv,
          $urandom_range(0, 99) < pr, took);
      n++;
    end
    chk("frame_inputs", pix, W * H);
    bus.in_valid = 1'b0;
    chk("frame_done", frame_done, 1);
    chk("busy_in_done", busy, 1);
    chk("in_ready_done", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("frame_done_pulse", frame_done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_2x2(input string tag);
    int ref_v[8];
    ref_v = '{0, 2, 4, 6, 16, 18, 20, 22};
    chk({tag, "_count"}, outq.size(), 8);
    for (int i = 0; i < 8 && i < outq.size(); i++)
      chk(tag, outq[i], ref_v[i]);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_sof"}, bus.out_sof, 0);
    chk({tag, "_eol"}, bus.out_eol, 0);
    chk({tag, "_eof"}, bus.out_eof, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    bit took;
    int cx, cy;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = 8'h5a;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", bus.in_ready, 0);

    // 2x2 back-to-back, sequential data
    seq = 1'b1;
    do_start(2, 2);
    run_rest(100, 100);
    chk_2x2("dec22_out");

    // 3x1
    do_start(3, 1);
    run_rest(100, 100);
    chk("dec31_count", outq.size(), 12);

    // clamp: 0 -> 1, 7 -> 4
    do_start(0, 7);
    run_rest(100, 100);
    chk("clamp_count", outq.size(), 8);
    if (outq.size() == 8) chk("clamp_last", outq[7], 7);

    // stall on kept pixel 2, dropped pixel 3 consumed under out_ready=0
    do_start(2, 2);
    cyc(1, 1, took);
    cyc(1, 1, took);
    repeat (5) cyc(1, 0, took);
    chk("stall_hold", pix, 2);
    cyc(1, 1, took);
    cyc(1, 0, took);
    chk("drop_consumed", pix, 4);
    run_rest(100, 100);
    chk_2x2("stall_out");

    // abort after 10 inputs, with ignored mid-run start
    do_start(2, 2);
    while (pix < 5) cyc(1, 1, took);
    start = 1'b1;
    cfg_dec_x = DW'(3);
    cfg_dec_y = DW'(1);
    cyc(1, 1, took);
    start = 1'b0;
    while (pix < 10) cyc(1, 1, took);
    bus.in_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_no_done", frame_done, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("abort_no_done2", frame_done, 0);

    // start+abort together in IDLE stays IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    do_start(2, 2);
    run_rest(100, 100);
    chk_2x2("post_abort_out");

    // randomized frames: data, gaps, backpressure, factors
    seq = 1'b0;
    for (int f = 0; f < 8; f++) begin
      cx = int'($urandom_range(0, 7));
      cy = int'($urandom_range(0, 7));
      do_start(cx, cy);
      run_rest(70, 60);
      chk("rand_count", outq.size(),
          ((W + edx - 1) / edx) * ((H + edy - 1) / edy));
    end

    // reset mid-frame after 13 inputs
    seq = 1'b1;
    do_start(2, 2);
    while (pix < 13) cyc(1, 1, took);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(2, 2);
    run_rest(100, 100);
    chk_2x2("post_reset_out");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
